// File: rtl/uart_tx_arbiter_if.sv
// Handshake and status bundle between two byte requesters, the arbiter and one uart_tx.
// Member names follow the established port names of the arbiter.
interface uart_tx_arbiter_if;
  logic [7:0]  req0_data;
  logic        req0_valid;
  logic        req0_ready;
  logic [7:0]  req1_data;
  logic        req1_valid;
  logic        req1_ready;
  logic [7:0]  sdata;
  logic        tx_start;
  logic        tx_busy;
  logic        grant;
  logic        timeout_err;
  logic [15:0] sent0;
  logic [15:0] sent1;

  modport master (
    input  req0_data, req0_valid, req1_data, req1_valid, tx_busy,
    output req0_ready, req1_ready, sdata, tx_start, grant, timeout_err, sent0, sent1
  );

  modport slave (
    output req0_data, req0_valid, req1_data, req1_valid, tx_busy,
    input  req0_ready, req1_ready, sdata, tx_start, grant, timeout_err, sent0, sent1
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter of two byte requesters onto one uart_tx; accepts only in IDLE (combinational ready),
// tx_start one cycle after accept, held until busy is seen or TIMEOUT cycles pass; requesters stall meanwhile.
module uart_tx_arbiter #(
  parameter int unsigned TIMEOUT = 16
) (
  input logic               clk,
  input logic               rst_uart,
  uart_tx_arbiter_if.master bus
);
  typedef enum logic [1:0] {IDLE, START, WAIT_BUSY, WAIT_DONE} state_t;

  localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT - 1);

  state_t      state_q;
  logic [7:0]  sdata_q;
  logic        tx_start_q;
  logic        grant_q;
  logic        last_grant_q;
  logic        timeout_err_q;
  logic [15:0] timer_q;
  logic [15:0] sent0_q;
  logic [15:0] sent1_q;
  logic        sel;
  logic        accept;

  // On a tie the requester that did not finish the previous transfer wins.
  always_comb begin
    sel = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      sel = ~last_grant_q;
    end else if (bus.req1_valid) begin
      sel = 1'b1;
    end
    accept = (state_q == IDLE) && !rst_uart && (bus.req0_valid || bus.req1_valid);
  end

  assign bus.req0_ready  = accept && !sel;
  assign bus.req1_ready  = accept && sel;
  assign bus.sdata       = sdata_q;
  assign bus.tx_start    = tx_start_q;
  assign bus.grant       = grant_q;
  assign bus.timeout_err = timeout_err_q;
  assign bus.sent0       = sent0_q;
  assign bus.sent1       = sent1_q;

  always_ff @(posedge clk or posedge rst_uart) begin
    if (rst_uart) begin
      state_q       <= IDLE;
      sdata_q       <= 8'h00;
      tx_start_q    <= 1'b0;
      grant_q       <= 1'b0;
      last_grant_q  <= 1'b1;
      timer_q       <= 16'd0;
      timeout_err_q <= 1'b0;
      sent0_q       <= 16'd0;
      sent1_q       <= 16'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            sdata_q <= sel ? bus.req1_data : bus.req0_data;
            grant_q <= sel;
            state_q <= START;
          end
        end
        START: begin
          tx_start_q <= 1'b1;
          timer_q    <= 16'd0;
          state_q    <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (bus.tx_busy) begin
            tx_start_q <= 1'b0;
            state_q    <= WAIT_DONE;
          end else if (timer_q == TIMER_LAST) begin
            // Abandoned byte: counters and round-robin history stay untouched.
            tx_start_q    <= 1'b0;
            timeout_err_q <= 1'b1;
            state_q       <= IDLE;
          end else begin
            timer_q <= timer_q + 16'd1;
          end
        end
        WAIT_DONE: begin
          if (!bus.tx_busy) begin
            if (grant_q) begin
              sent1_q <= sent1_q + 16'd1;
            end else begin
              sent0_q <= sent0_q + 16'd1;
            end
            last_grant_q <= grant_q;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: transaction-timeline model checked every cycle plus directed literal checks.
module tb_uart_tx_arbiter;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst_uart;
  always #5 clk = ~clk;

  uart_tx_arbiter_if bus ();

  uart_tx_arbiter #(.TIMEOUT(TO)) dut (
    .clk      (clk),
    .rst_uart (rst_uart),
    .bus      (bus)
  );

  int tests = 0;
  int fails = 0;

  // Model: one optional in-flight transfer described by owner, byte and acceptance time.
  bit          m_inflight, m_busy_seen, m_own, m_last, m_grant, m_tstart, m_terr;
  logic [7:0]  m_sdata;
  logic [15:0] m_sent [2];
  int          m_cyc, m_acc;

  // uart_tx stand-in
  bit busy_stuck = 1'b0;
  int busy_len   = 3;
  int u_cnt      = 0;
  bit u_arm      = 1'b0;

  int order [4] = '{0, 1, 0, 1};

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(logic v0, logic v1, bit last);
    if (v0 && v1) return last ? 0 : 1;
    if (v0) return 0;
    if (v1) return 1;
    return -1;
  endfunction

  task automatic model_reset();
    m_inflight = 0; m_busy_seen = 0; m_own = 0; m_last = 1; m_grant = 0;
    m_tstart = 0; m_terr = 0; m_sdata = 8'h00; m_sent[0] = 16'd0; m_sent[1] = 16'd0;
    m_cyc = 0; m_acc = 0;
  endtask

  // Called at each rising edge with the inputs that were present before it.
  task automatic model_step();
    int s;
    if (rst_uart) begin
      model_reset();
      return;
    end
    m_cyc++;
    if (!m_inflight) begin
      s = pick(bus.req0_valid, bus.req1_valid, m_last);
      if (s >= 0) begin
        m_inflight = 1; m_busy_seen = 0; m_acc = m_cyc;
        m_own = (s == 1); m_grant = (s == 1);
        m_sdata = (s == 1) ? bus.req1_data : bus.req0_data;
      end
    end else if (m_cyc - m_acc == 1) begin
      m_tstart = 1;
    end else if (!m_busy_seen) begin
      if (bus.tx_busy) begin
        m_busy_seen = 1; m_tstart = 0;
      end else if (m_cyc - m_acc == TO + 1) begin
        m_tstart = 0; m_terr = 1; m_inflight = 0;
      end
    end else if (!bus.tx_busy) begin
      m_sent[m_own] = m_sent[m_own] + 16'd1;
      m_last = m_own; m_inflight = 0;
    end
  endtask

  task automatic uart_step();
    if (rst_uart) begin
      bus.tx_busy = 1'b0; u_cnt = 0; u_arm = 0;
    end else if (busy_stuck) begin
      bus.tx_busy = 1'b0;
    end else if (u_cnt > 0) begin
      u_cnt--;
      if (u_cnt == 0) bus.tx_busy = 1'b0;
    end else if (u_arm) begin
      u_arm = 0; bus.tx_busy = 1'b1; u_cnt = busy_len;
    end else if (bus.tx_start) begin
      u_arm = 1;
    end
  endtask

  task automatic compare_all();
    int  s;
    logic r0, r1;
    s  = pick(bus.req0_valid, bus.req1_valid, m_last);
    r0 = !rst_uart && !m_inflight && (s == 0);
    r1 = !rst_uart && !m_inflight && (s == 1);
    check("req0_ready", 32'(bus.req0_ready), 32'(r0));
    check("req1_ready", 32'(bus.req1_ready), 32'(r1));
    check("sdata", 32'(bus.sdata), 32'(m_sdata));
    check("tx_start", 32'(bus.tx_start), 32'(m_tstart));
    check("grant", 32'(bus.grant), 32'(m_grant));
    check("timeout_err", 32'(bus.timeout_err), 32'(m_terr));
    check("sent0", 32'(bus.sent0), 32'(m_sent[0]));
    check("sent1", 32'(bus.sent1), 32'(m_sent[1]));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    uart_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic ticks(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    rst_uart = 1'b1;
    model_reset();
    ticks(2);
    rst_uart = 1'b0;
  endtask

  // Runs cycles until one requester is accepted; who = -1 when none is within budget.
  task automatic serve(output int who);
    who = -1;
    #1;
    for (int i = 0; i < 60 && who < 0; i++) begin
      if (bus.req0_ready) who = 0;
      else if (bus.req1_ready) who = 1;
      tick();
    end
  endtask

  initial begin
    int who;
    int cnt;
    rst_uart = 1'b1;
    bus.req0_data = 8'h00; bus.req0_valid = 1'b0;
    bus.req1_data = 8'h00; bus.req1_valid = 1'b0;
    bus.tx_busy = 1'b0;
    model_reset();
    ticks(3);
    check("rst_sdata", 32'(bus.sdata), 32'h00);
    check("rst_tx_start", 32'(bus.tx_start), 32'h0);
    check("rst_sent0", 32'(bus.sent0), 32'h0);
    rst_uart = 1'b0;
    tick();

    // Both requesters continuously valid: strict alternation starting with req0.
    busy_len = 3;
    bus.req0_data = 8'h30; bus.req0_valid = 1'b1;
    bus.req1_data = 8'h0a; bus.req1_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      serve(who);
      check("rr_order", 32'(who), 32'(order[k]));
      check("rr_grant", 32'(bus.grant), 32'(order[k]));
      check("rr_sdata", 32'(bus.sdata), (order[k] == 0) ? 32'h30 : 32'h0a);
    end
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    ticks(12);
    check("rr_sent0", 32'(bus.sent0), 32'd2);
    check("rr_sent1", 32'(bus.sent1), 32'd2);

    // Single requester, uart busy for 20 cycles.
    do_reset();
    tick();
    busy_len = 20;
    bus.req0_data = 8'h50; bus.req0_valid = 1'b1;
    #1;
    check("single_ready_on", 32'(bus.req0_ready), 32'h1);
    tick();
    check("single_ready_pulse", 32'(bus.req0_ready), 32'h0);
    check("single_sdata_lead", 32'(bus.sdata), 32'h50);
    check("single_start_after", 32'(bus.tx_start), 32'h0);
    bus.req0_valid = 1'b0;
    tick();
    check("single_start_up", 32'(bus.tx_start), 32'h1);
    tick();
    check("single_start_hold", 32'(bus.tx_start), 32'h1);
    tick();
    check("single_start_drop", 32'(bus.tx_start), 32'h0);
    ticks(25);
    check("single_sent0", 32'(bus.sent0), 32'd1);
    check("single_sent1", 32'(bus.sent1), 32'd0);

    // Reset pulsed while the uart is still busy.
    bus.req0_data = 8'h5a; bus.req0_valid = 1'b1;
    serve(who);
    check("rst_mid_accept", 32'(who), 32'd0);
    bus.req0_valid = 1'b0;
    ticks(4);
    bus.req0_data = 8'h11; bus.req0_valid = 1'b1;
    bus.req1_data = 8'h22; bus.req1_valid = 1'b1;
    #2;
    rst_uart = 1'b1;
    model_reset();
    #1;
    check("arst_tx_start", 32'(bus.tx_start), 32'h0);
    check("arst_sdata", 32'(bus.sdata), 32'h00);
    check("arst_sent0", 32'(bus.sent0), 32'h0);
    check("arst_ready0", 32'(bus.req0_ready), 32'h0);
    check("arst_ready1", 32'(bus.req1_ready), 32'h0);
    ticks(2);
    rst_uart = 1'b0;
    serve(who);
    check("arst_first_tie", 32'(who), 32'd0);
    check("arst_tie_sdata", 32'(bus.sdata), 32'h11);
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    ticks(28);

    // uart never raises busy.
    do_reset();
    tick();
    busy_stuck = 1'b1;
    bus.req0_data = 8'h77; bus.req0_valid = 1'b1;
    serve(who);
    bus.req0_valid = 1'b0;
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (bus.tx_start) cnt++;
    end
    check("to_start_cycles", 32'(cnt), 32'd16);
    check("to_err", 32'(bus.timeout_err), 32'h1);
    check("to_sent0", 32'(bus.sent0), 32'd0);
    check("to_sent1", 32'(bus.sent1), 32'd0);
    busy_stuck = 1'b0;
    busy_len = 2;
    bus.req1_data = 8'h12; bus.req1_valid = 1'b1;
    serve(who);
    check("to_next_accept", 32'(who), 32'd1);
    bus.req1_valid = 1'b0;
    ticks(10);
    check("to_next_sent1", 32'(bus.sent1), 32'd1);
    check("to_err_sticky", 32'(bus.timeout_err), 32'h1);

    // Counter wrap: sent0 brought near its limit, then two more req0 bytes.
    do_reset();
    tick();
    busy_len = 1;
    bus.req1_data = 8'h0b; bus.req1_valid = 1'b1;
    serve(who);
    bus.req1_valid = 1'b0;
    ticks(8);
    check("wrap_pre_sent1", 32'(bus.sent1), 32'd1);
    force dut.sent0_q = 16'hfffe;
    #1;
    release dut.sent0_q;
    m_sent[0] = 16'hfffe;
    bus.req0_data = 8'hf0; bus.req0_valid = 1'b1;
    serve(who);
    bus.req0_valid = 1'b0;
    ticks(8);
    check("wrap_max", 32'(bus.sent0), 32'hffff);
    bus.req0_data = 8'hf1; bus.req0_valid = 1'b1;
    serve(who);
    bus.req0_valid = 1'b0;
    ticks(8);
    check("wrap_zero", 32'(bus.sent0), 32'h0);
    check("wrap_sent1", 32'(bus.sent1), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16; the maximum cycles to wait for tx_busy after asserting tx_start (legal range 2..65535).
REQ-002 SHALL have port clk, input, 1; the single clock, rising-edge active.
REQ-003 SHALL have port rst_uart, input, 1; asynchronous, active-high reset.
REQ-004 SHALL have port req0_data, input, 8; byte offered by requester 0 (core output).
REQ-005 SHALL have port req0_valid, input, 1; requester 0 byte valid.
REQ-006 SHALL have port req0_ready, output, 1; requester 0 byte accepted this cycle.
REQ-007 SHALL have ports req1_data (input, 8), req1_valid (input, 1) and req1_ready (output, 1); same meanings for requester 1 (debug monitor).
REQ-008 SHALL have port sdata, output, 8; byte presented to the uart_tx data input.
REQ-009 SHALL have port tx_start, output, 1; uart_tx start request.
REQ-010 SHALL have port tx_busy, input, 1; uart_tx busy flag.
REQ-011 SHALL have port grant, output, 1; index of the requester owning the current or last transfer.
REQ-012 SHALL have port timeout_err, output, 1; sticky flag, tx_busy never seen within TIMEOUT.
REQ-013 SHALL have ports sent0 and sent1, output, 16 each; completed-byte counts per requester.

Function
REQ-014 SHALL implement states IDLE, START, WAIT_BUSY and WAIT_DONE.
REQ-015 SHALL, in IDLE only, drive reqN_ready high combinationally for exactly the selected requester; in all other states both readies SHALL be 0.
REQ-016 SHALL select as follows: only one valid -> that one; both valid -> the requester not equal to last_grant (round-robin); none valid -> no ready asserted.
REQ-017 SHALL, at the accepting edge (valid && ready), register the selected byte into sdata, set grant, and go to START.
REQ-018 SHALL hold sdata stable from the accepting edge until the return to IDLE.
REQ-019 SHALL, from START, set tx_start=1 on the next edge and go to WAIT_BUSY, clearing a 16-bit timer; sdata therefore leads tx_start by one cycle.
REQ-020 SHALL, in WAIT_BUSY with tx_busy=1, clear tx_start and go to WAIT_DONE on that edge.
REQ-021 SHALL, in WAIT_BUSY with tx_busy=0, increment the timer; when the timer equals TIMEOUT-1, clear tx_start, set timeout_err, and return to IDLE without updating sent counters or last_grant.
REQ-022 SHALL, in WAIT_DONE with tx_busy=0, increment sent[grant] (16-bit, wrapping 65535 -> 0), set last_grant=grant, and go to IDLE.
REQ-023 SHALL accept a new byte no earlier than the first IDLE cycle after completion, giving a minimum of one IDLE cycle between transfers.
REQ-024 SHALL ignore data changes on a non-accepted requester; the requester SHALL keep valid and data stable until ready.
REQ-025 SHALL keep timeout_err at 1 once set, until reset.
REQ-026 SHALL treat tx_busy already high in IDLE or START as don't-care; only WAIT_BUSY and WAIT_DONE sample it.

Reset
REQ-027 SHALL, on rst_uart=1 and regardless of clk, immediately force: state=IDLE, sdata=8'h00, tx_start=0, grant=0, last_grant=1, timer=0, timeout_err=0, sent0=sent1=0.
REQ-028 SHALL abandon any in-flight transfer on reset mid-operation, with tx_start dropping asynchronously; readies SHALL be 0 while rst_uart=1.
REQ-029 SHALL resume arbitration on the first rising edge after rst_uart deasserts, giving requester 0 priority on the first tie.

Verification
REQ-030 SHALL be verified by: req0 only, byte 8'h50, uart_tx model busy 1 cycle after start for 20 cycles -> req0_ready pulses 1 cycle, sdata=8'h50 one cycle before tx_start, tx_start drops on the first busy edge, sent0=1, sent1=0.
REQ-031 SHALL be verified by: req0 and req1 both continuously valid (8'h30, 8'h0a) for 4 transfers -> serviced order 0,1,0,1, sent0=2, sent1=2, grant alternates.
REQ-032 SHALL be verified by: tx_busy stuck at 0, TIMEOUT=16 -> tx_start high exactly 16 cycles, then timeout_err=1, state IDLE, sent0=sent1=0, next valid accepted.
REQ-033 SHALL be verified by: rst_uart pulsed high during WAIT_DONE -> tx_start=0, sdata=8'h00 and counters 0 without a clock edge; first tie after release grants req0.
REQ-034 SHALL be verified by: sent0 preloaded via 65535 completed req0 transfers, then one more -> sent0=0 with no effect on sent1.
